// File: rtl/zap_decode_skid_buffer.sv
// ============================================================================
// zap_decode_skid_buffer
// ----------------------------------------------------------------------------
// Decode-to-issue pipeline register with an integrated DEPTH-entry skid FIFO.
//
// The output register (o_payload_ff / o_valid_ff) has the same prioritised
// clear/stall behaviour as the decode output flops. Decoded instructions that
// arrive while downstream is stalled are kept in the FIFO. Fetch is told to
// stall (o_stall_from_decode) one entry before the FIFO is full. That leaves
// room for the instruction already in flight from fetch.
//
// Priority, highest first:
//   i_clear_from_writeback  flush
//   i_data_stall            hold
//   i_clear_from_alu        flush
//   i_stall_from_shifter    hold
//   i_stall_from_issue      hold
//
// Optional feature macro: ZAP_DECODE_SKID_BYPASS_EN
//   defined     : when the FIFO is empty on an advance cycle, a valid input
//                 goes straight to the output register (1-cycle latency).
//   not defined : every instruction passes through the FIFO (2-cycle
//                 latency). The output register is fed only from the FIFO
//                 head.
//
// Parameters:
//   WIDTH      payload width in bits
//   DEPTH      FIFO entries (power of two, >= 2)
//   CLEAR_VAL  payload driven on reset or clear
//
// Ports:
//   i_clk                   clock, rising edge
//   i_reset_n               asynchronous active-low reset
//   i_clear_from_writeback  flush, priority 1
//   i_data_stall            hold,  priority 2
//   i_clear_from_alu        flush, priority 3
//   i_stall_from_shifter    hold,  priority 4
//   i_stall_from_issue      hold,  priority 5
//   i_payload               decoded instruction
//   i_valid                 i_payload valid this cycle
//   o_payload_ff            registered payload to issue
//   o_valid_ff              o_payload_ff valid
//   o_stall_from_decode     stall fetch / PC (count >= DEPTH-1)
//   o_count                 FIFO occupancy
//   o_overflow_ff           sticky: an input was dropped (cleared by reset)
// ============================================================================
module zap_decode_skid_buffer #(
   parameter int                WIDTH     = 128,
   parameter int                DEPTH     = 4,
   parameter logic [WIDTH-1:0]  CLEAR_VAL = {WIDTH{1'b0}}
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_clear_from_writeback,
   input  logic                         i_data_stall,
   input  logic                         i_clear_from_alu,
   input  logic                         i_stall_from_shifter,
   input  logic                         i_stall_from_issue,
   input  logic [WIDTH-1:0]             i_payload,
   input  logic                         i_valid,
   output logic [WIDTH-1:0]             o_payload_ff,
   output logic                         o_valid_ff,
   output logic                         o_stall_from_decode,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_overflow_ff
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
   localparam logic [CW-1:0] C_DEPTH_M1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] C_PTR_ONE  = PW'(1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_payload_ff;
   logic             r_valid_ff;
   logic             r_overflow_ff;

   // -------------------------------------------------------------------------
   // Control decode
   // -------------------------------------------------------------------------
   logic             w_clr;
   logic             w_hold;
   logic             w_adv;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_bypass;
   logic             w_push;
   logic             w_drop;
   logic [WIDTH-1:0] w_head;
   logic [WIDTH-1:0] w_payload_next;
   logic             w_valid_next;
   logic [CW-1:0]    w_count_next;

   // i_data_stall masks the ALU clear. Only a writeback clear can break
   // through a data stall.
   assign w_clr  = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
   assign w_hold = ~w_clr & (i_data_stall | i_stall_from_shifter | i_stall_from_issue);
   assign w_adv  = ~w_clr & ~w_hold;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_DEPTH);
   assign w_head  = r_mem[r_rd_ptr];

   assign w_pop   = w_adv & ~w_empty;

`ifdef ZAP_DECODE_SKID_BYPASS_EN
   // An empty FIFO on an advance cycle lets the input skip the queue.
   assign w_bypass = w_adv & w_empty & i_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push = ~w_clr & i_valid & ~w_bypass & (~w_full | w_pop);
   assign w_drop = ~w_clr & i_valid & w_full & ~w_pop;

   // -------------------------------------------------------------------------
   // Output register next-state
   // -------------------------------------------------------------------------
   always_comb begin
      w_payload_next = r_payload_ff;
      w_valid_next   = r_valid_ff;
      if (w_clr) begin
         w_payload_next = CLEAR_VAL;
         w_valid_next   = 1'b0;
      end else if (w_adv) begin
         if (w_pop) begin
            w_payload_next = w_head;
            w_valid_next   = 1'b1;
`ifdef ZAP_DECODE_SKID_BYPASS_EN
         end else if (w_bypass) begin
            w_payload_next = i_payload;
            w_valid_next   = 1'b1;
`endif
         end else begin
            w_payload_next = CLEAR_VAL;
            w_valid_next   = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Occupancy next-state. Push and pop together leave the count unchanged.
   // -------------------------------------------------------------------------
   always_comb begin
      w_count_next = r_count;
      if (w_clr) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - C_CNT_ONE;
      end
   end

   // -------------------------------------------------------------------------
   // Storage array. It has no reset: reset or clear empties the FIFO by
   // clearing the pointers and the count, so old contents are never read.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_payload;
      end
   end

   // -------------------------------------------------------------------------
   // Control and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_payload_ff  <= CLEAR_VAL;
         r_valid_ff    <= 1'b0;
         r_overflow_ff <= 1'b0;
      end else begin
         r_count      <= w_count_next;
         r_payload_ff <= w_payload_next;
         r_valid_ff   <= w_valid_next;

         // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
         if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
         end

         if (w_drop) begin
            r_overflow_ff <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_payload_ff        = r_payload_ff;
   assign o_valid_ff          = r_valid_ff;
   assign o_count             = r_count;
   assign o_overflow_ff       = r_overflow_ff;
   // Stall one entry early to leave room for the instruction in flight.
   assign o_stall_from_decode = (r_count >= C_DEPTH_M1);

endmodule

// File: tb/tb_zap_decode_skid_buffer.sv
// ============================================================================
// tb_zap_decode_skid_buffer
// Directed scenarios plus randomized traffic. The results are compared every
// cycle against a queue-based reference model of the skid buffer.
// ============================================================================
module tb_zap_decode_skid_buffer;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);
   localparam logic [W-1:0] CV = 16'hC1EA;
`ifdef ZAP_DECODE_SKID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          clr_wb = 1'b0;
   logic          dstall = 1'b0;
   logic          clr_alu = 1'b0;
   logic          st_sh  = 1'b0;
   logic          st_is  = 1'b0;
   logic          vld    = 1'b0;
   logic [W-1:0]  pay    = '0;

   logic [W-1:0]  o_pay;
   logic          o_vld;
   logic          o_stall;
   logic [CW-1:0] o_cnt;
   logic          o_ovf;

   zap_decode_skid_buffer #(
      .WIDTH     (W),
      .DEPTH     (D),
      .CLEAR_VAL (CV)
   ) dut (
      .i_clk                  (clk),
      .i_reset_n              (rst_n),
      .i_clear_from_writeback (clr_wb),
      .i_data_stall           (dstall),
      .i_clear_from_alu       (clr_alu),
      .i_stall_from_shifter   (st_sh),
      .i_stall_from_issue     (st_is),
      .i_payload              (pay),
      .i_valid                (vld),
      .o_payload_ff           (o_pay),
      .o_valid_ff             (o_vld),
      .o_stall_from_decode    (o_stall),
      .o_count                (o_cnt),
      .o_overflow_ff          (o_ovf)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [W-1:0] m_q[$];
   bit           m_v;
   logic [W-1:0] m_p;
   bit           m_ovf;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_v   = 1'b0;
      m_p   = CV;
      m_ovf = 1'b0;
   endtask

   // One clock edge of behaviour, based on the inputs present at the edge.
   task automatic model_edge();
      bit clr, hold, byp;
      clr  = clr_wb || (!dstall && clr_alu);
      hold = !clr && (dstall || st_sh || st_is);
      byp  = 1'b0;
      if (clr) begin
         m_q.delete();
         m_v = 1'b0;
         m_p = CV;
      end else begin
         if (!hold) begin
            if (m_q.size() > 0) begin
               m_p = m_q.pop_front();
               m_v = 1'b1;
            end else if (BYP && vld) begin
               m_p = pay;
               m_v = 1'b1;
               byp = 1'b1;
            end else begin
               m_p = CV;
               m_v = 1'b0;
            end
         end
         if (vld && !byp) begin
            if (m_q.size() < D) m_q.push_back(pay);
            else                m_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},    {31'd0, o_vld},   {31'd0, m_v});
      chk({tag, ".payload"},  {16'd0, o_pay},   {16'd0, m_p});
      chk({tag, ".count"},    {29'd0, o_cnt},   m_q.size());
      chk({tag, ".stall"},    {31'd0, o_stall}, (m_q.size() >= D-1) ? 32'd1 : 32'd0);
      chk({tag, ".overflow"}, {31'd0, o_ovf},   {31'd0, m_ovf});
   endtask

   task automatic set_in(input bit wb, input bit ds, input bit ca, input bit sh,
                         input bit is, input bit v, input logic [W-1:0] p);
      clr_wb = wb; dstall = ds; clr_alu = ca; st_sh = sh; st_is = is; vld = v; pay = p;
   endtask

   // Advance one clock and compare all outputs 1 time unit after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      $display("cyc=%0d %s in[wb=%0b ds=%0b ca=%0b sh=%0b is=%0b v=%0b p=%h] out[v=%0b p=%h cnt=%0d st=%0b ovf=%0b]",
               cyc, tag, clr_wb, dstall, clr_alu, st_sh, st_is, vld, pay,
               o_vld, o_pay, o_cnt, o_stall, o_ovf);
      check_all(tag);
   endtask

   // Asynchronous reset pulse, asserted between clock edges.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();

      // Reset held: toggle the inputs, the outputs must keep their reset values.
      for (int i = 0; i < 3; i++) begin
         set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'b1, W'($urandom));
         @(posedge clk);
         #1;
         check_all("rst_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, '0);

      // Latency of a single instruction
      set_in(0, 0, 0, 0, 0, 1, 16'h00A5);
      step("lat0");
      chk("lat.first_cycle_valid", {31'd0, o_vld}, {31'd0, BYP});
      set_in(0, 0, 0, 0, 0, 0, '0);
      step("lat1");
      step("lat2");

      // Stall fill, overflow, then drain
      for (int i = 1; i <= 4; i++) begin
         set_in(0, 0, 0, 0, 1, 1, W'(i));
         step("fill");
      end
      chk("fill.count_full", {29'd0, o_cnt}, 32'd4);
      set_in(0, 0, 0, 0, 1, 1, 16'h0005);
      step("ovf_push");
      chk("ovf.set", {31'd0, o_ovf}, 32'd1);
      set_in(0, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) step("drain");
      chk("ovf.sticky", {31'd0, o_ovf}, 32'd1);

      // Priority: data stall masks the ALU clear, writeback clear wins
      async_reset("rst_mid1");
      set_in(0, 0, 0, 0, 1, 1, 16'h0021); step("pri_fill");
      set_in(0, 0, 0, 0, 1, 1, 16'h0022); step("pri_fill");
      set_in(0, 1, 1, 0, 0, 0, '0);       step("pri_alu_masked");
      chk("pri.no_flush_count", {29'd0, o_cnt}, 32'd2);
      set_in(1, 1, 0, 0, 0, 1, 16'h0023); step("pri_wb_clear");
      chk("pri.clear_valid", {31'd0, o_vld}, 32'd0);
      chk("pri.clear_payload", {16'd0, o_pay}, {16'd0, CV});

      // Wrap-around stream with periodic shifter stalls
      async_reset("rst_mid2");
      for (int i = 0; i < 10; i++) begin
         set_in(0, 0, 0, (i % 3) == 2, 0, 1, W'(16'h10 + i));
         step("wrap");
      end
      set_in(0, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 6; i++) step("wrap_drain");
      chk("wrap.no_overflow", {31'd0, o_ovf}, 32'd0);

      // Simultaneous push and pop when the FIFO is full
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 0, 1, 1, W'(16'h60 + i));
         step("pp_fill");
      end
      set_in(0, 0, 0, 0, 0, 1, 16'h0077);
      step("pp_both");
      chk("pp.count_held", {29'd0, o_cnt}, 32'd4);
      chk("pp.no_overflow", {31'd0, o_ovf}, 32'd0);
      set_in(0, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) step("pp_drain");

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
         set_in($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
                W'($urandom));
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/zap_decode_skid_buffer.md
# zap_decode_skid_buffer

Parametrised decode-to-issue pipeline register with an integrated DEPTH-entry skid FIFO. It sits between decode logic and the issue stage and honours the same prioritised clear/stall inputs as the decode output flops. It also absorbs decoded instructions while downstream is stalled, so fetch backpressure (`o_stall_from_decode`) arrives early instead of on the same cycle. The payload is an opaque WIDTH-bit vector, typically the concatenation of all decode `_nxt` fields.

## Interface
- `WIDTH`, 128: payload width in bits.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥ 2.
- `CLEAR_VAL`, `{WIDTH{1'b0}}`: payload driven on reset or clear. Integrators set its condition-code field to NV.
- `i_clk`  in  1: clock. All state updates on the rising edge.
- `i_reset_n`  in  1: reset, asynchronous, active-low.
- `i_clear_from_writeback`  in  1: flush, priority 1 (highest).
- `i_data_stall`  in  1: hold, priority 2.
- `i_clear_from_alu`  in  1: flush, priority 3.
- `i_stall_from_shifter`  in  1: hold, priority 4.
- `i_stall_from_issue`  in  1: hold, priority 5.
- `i_payload`  in  WIDTH: decoded instruction.
- `i_valid`  in  1: `i_payload` is valid this cycle.
- `o_payload_ff`  out  WIDTH: registered payload to issue.
- `o_valid_ff`  out  1: `o_payload_ff` is valid.
- `o_stall_from_decode`  out  1: stall fetch and PC.
- `o_count`  out  $clog2(DEPTH+1): current FIFO occupancy.
- `o_overflow_ff`  out  1: sticky error, set when input is dropped.

## Operation
- Priority decode each cycle, first match wins:
  - `clr` = `i_clear_from_writeback` | (!`i_data_stall` & `i_clear_from_alu`).
  - `hold` = !`clr` & (`i_data_stall` | `i_stall_from_shifter` | `i_stall_from_issue`).
  - `adv` = !`clr` & !`hold`.
- On `clr`:
  - Read/write pointers and count go to 0.
  - `o_valid_ff` goes to 0 and `o_payload_ff` to `CLEAR_VAL`.
  - `i_valid` in the same cycle is discarded and is not an overflow.
- On `hold`:
  - The output register is frozen.
  - Push if `i_valid` & count < DEPTH.
- On `adv`:
  - If count > 0: the output register loads the FIFO head with valid 1 (pop).
  - Else, with the bypass macro, if `i_valid`: the output register loads `i_payload` directly with no push.
  - Otherwise: the output register loads `CLEAR_VAL` with valid 0.
  - A push happens if `i_valid` and the input was not bypassed, and either count < DEPTH or a pop occurs in this cycle. Push and pop together leave the count unchanged.
- Drop condition: `i_valid` & !`clr` & count == DEPTH & no pop.
  - The input is lost and `o_overflow_ff` is set.
  - `o_overflow_ff` clears only on reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates logically at DEPTH, never exceeds it, and never underflows.
- `o_stall_from_decode` = (count ≥ DEPTH−1), combinational from the count register. This leaves one slot for the instruction already in flight from fetch.

## Timing
- Reset values: `o_payload_ff` = `CLEAR_VAL`, `o_valid_ff` = 0, `o_count` = 0, `o_overflow_ff` = 0, `o_stall_from_decode` = 0, pointers = 0.
- Asserting `i_reset_n` mid-operation discards all FIFO contents immediately, asynchronously.
- Latency from `i_valid` to `o_valid_ff`:
  - 1 cycle with bypass and an empty FIFO.
  - 2 cycles otherwise (push, then pop).
- Throughput is one instruction per cycle in steady state with no stalls.
- `o_stall_from_decode` updates the cycle after the count change. It does not depend on the stall or clear inputs.
- `clr` takes effect on the next edge. There is no stale output in the cycle after a clear.

## Configuration
- `ZAP_DECODE_SKID_BYPASS_EN` defined: empty-FIFO bypass is active, giving 1-cycle latency.
- Not defined: every instruction passes through the FIFO, giving a fixed 2-cycle latency. The output register is driven only from the FIFO head, which makes the critical path shorter.

## Test plan
- Reset: hold `i_reset_n` = 0, toggle inputs → all outputs at reset values and `o_count` = 0. Release reset, apply `i_valid` with payload 0xA5 → `o_valid_ff` = 1 with payload 0xA5 after 1 cycle (bypass) or 2 cycles (no bypass).
- Stall fill: assert `i_stall_from_issue`, push 0x1,0x2,0x3,0x4 (DEPTH=4) → `o_count` = 3 then 4, `o_stall_from_decode` = 1 from count 3. Release the stall → outputs 0x1..0x4 in order on consecutive cycles.
- Overflow: with DEPTH=4 full and held, push 0x5 → 0x5 dropped, `o_overflow_ff` = 1 and stays 1 after draining.
- Priority: `i_data_stall` = 1 and `i_clear_from_alu` = 1 with 2 entries → no flush, `o_count` = 2. Then `i_clear_from_writeback` = 1 with `i_data_stall` = 1 → `o_count` = 0, `o_valid_ff` = 0, payload = `CLEAR_VAL`.
- Wrap-around: stream 10 payloads 0x10..0x19 with `i_stall_from_shifter` asserted every third cycle → all 10 delivered in order, none lost, `o_overflow_ff` = 0.
- Simultaneous push and pop at full: count = 4, `adv` with `i_valid` payload 0x77 → head popped, 0x77 pushed, `o_count` stays 4, no overflow.
